// File: rtl/led_stream_sampler_if.sv
// Readout stream of the LED sampler: one captured sample per valid/ready handshake.
interface led_stream_if;
    logic        out_valid;
    logic        out_ready;
    logic [10:0] out_data;
    logic        out_last;

    modport master (output out_valid, output out_data, output out_last, input out_ready);
    modport slave  (input out_valid, input out_data, input out_last, output out_ready);
endinterface

// File: rtl/led_stream_sampler.sv
// Trigger-centred capture of {led_on_number, led} into a circular buffer,
// replayed oldest-first over a valid/ready stream once the window is complete.
module led_stream_sampler #(
    parameter int DEPTH    = 16,
    parameter int PRE_TRIG = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] led,
    input  logic [2:0] led_on_number,
    input  logic       arm,
    input  logic       trigger_ext,
    output logic       sampler_ready,
    led_stream_if.master out_if
);

    localparam int PW     = $clog2(DEPTH);
    localparam int CW     = PW + 1;
    localparam int POST_N = DEPTH - PRE_TRIG;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FILL,
        ST_WAIT,
        ST_POST,
        ST_DONE,
        ST_READ
    } state_t;

    logic [10:0]   mem [DEPTH];

    state_t        state_q, state_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] trig_addr_q, trig_addr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          trig_dly_q, trig_dly_d;
    logic [10:0]   out_data_q, out_data_d;
    logic          out_last_q, out_last_d;
    logic          out_valid_q, out_valid_d;
    logic          ready_q, ready_d;
    logic          wr_en;
    logic          trig_edge;

    assign trig_edge = trigger_ext & ~trig_dly_q;

    // cnt_q counts pre-trigger writes in FILL, post-trigger writes in WAIT/POST,
    // and the index of the word currently presented in READ.
    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        trig_addr_d = trig_addr_q;
        cnt_d       = cnt_q;
        trig_dly_d  = trigger_ext;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        wr_en       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (arm) begin
                    wr_ptr_d = '0;
                    cnt_d    = '0;
                    state_d  = ST_FILL;
                end
            end
            ST_FILL: begin
                wr_en    = 1'b1;
                wr_ptr_d = wr_ptr_q + 1'b1;
                if (cnt_q == CW'(PRE_TRIG - 1)) begin
                    cnt_d   = '0;
                    state_d = ST_WAIT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_WAIT: begin
                wr_en    = 1'b1;
                wr_ptr_d = wr_ptr_q + 1'b1;
                if (trig_edge) begin
                    trig_addr_d = wr_ptr_q;
                    cnt_d       = CW'(1);
                    state_d     = (POST_N == 1) ? ST_DONE : ST_POST;
                end
            end
            ST_POST: begin
                wr_en    = 1'b1;
                wr_ptr_d = wr_ptr_q + 1'b1;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == CW'(POST_N - 1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                rd_ptr_d   = trig_addr_q - PW'(PRE_TRIG);
                out_data_d = mem[trig_addr_q - PW'(PRE_TRIG)];
                out_last_d = 1'b0;
                cnt_d      = '0;
                state_d    = ST_READ;
            end
            ST_READ: begin
                if (out_if.out_ready) begin
                    if (out_last_q) begin
                        out_last_d = 1'b0;
                        state_d    = ST_IDLE;
                    end else begin
                        rd_ptr_d   = rd_ptr_q + 1'b1;
                        out_data_d = mem[rd_ptr_q + 1'b1];
                        cnt_d      = cnt_q + 1'b1;
                        out_last_d = (cnt_q == CW'(DEPTH - 2));
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Arm outside IDLE wins over any handshake or trigger in the same cycle.
        if (arm && (state_q != ST_IDLE)) begin
            wr_ptr_d   = '0;
            cnt_d      = '0;
            out_last_d = 1'b0;
            state_d    = ST_FILL;
        end

        out_valid_d = (state_d == ST_READ);
        ready_d     = (state_d == ST_DONE) || (state_d == ST_READ);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            trig_addr_q <= '0;
            cnt_q       <= '0;
            trig_dly_q  <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            out_valid_q <= 1'b0;
            ready_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            trig_addr_q <= trig_addr_d;
            cnt_q       <= cnt_d;
            trig_dly_q  <= trig_dly_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            out_valid_q <= out_valid_d;
            ready_q     <= ready_d;
        end
    end

    // Buffer contents are deliberately not reset; they are only read after a full capture.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_q] <= {led_on_number, led};
        end
    end

    assign sampler_ready    = ready_q;
    assign out_if.out_valid = out_valid_q;
    assign out_if.out_data  = out_data_q;
    assign out_if.out_last  = out_last_q;

endmodule

// File: tb/tb_led_stream_sampler.sv
// Directed bench for led_stream_sampler (DEPTH=16, PRE_TRIG=4): led counts up by
// one per cycle, so every expected readout word follows from the trigger-cycle led value.
module tb_led_stream_sampler;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] led = '0;
    logic [2:0] led_on_number = '0;
    logic       arm = 1'b0;
    logic       trigger_ext = 1'b0;
    logic       sampler_ready;
    logic [7:0] ledv = '0;
    logic [7:0] edge_led;
    int         checks = 0;
    int         errors = 0;

    led_stream_if out_if ();

    led_stream_sampler #(.DEPTH(16), .PRE_TRIG(4)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .led           (led),
        .led_on_number (led_on_number),
        .arm           (arm),
        .trigger_ext   (trigger_ext),
        .sampler_ready (sampler_ready),
        .out_if        (out_if.master)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [10:0] exp_word(input logic [7:0] l);
        return {l[2:0] ^ 3'b101, l};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive inputs for one clock, then sample 1 time unit after the rising edge.
    task automatic cycle(input logic a, input logic t, input logic r);
        arm              = a;
        trigger_ext      = t;
        out_if.out_ready = r;
        led              = ledv;
        led_on_number    = ledv[2:0] ^ 3'b101;
        @(posedge clk);
        #1;
        ledv++;
    endtask

    task automatic capture(input int pre_cycles, output logic [7:0] e);
        for (int i = 0; i < pre_cycles; i++) cycle(1'b0, 1'b0, 1'b1);
        e = ledv;
        cycle(1'b0, 1'b1, 1'b1);
    endtask

    // stop_mode 1: async reset at stop_word; stop_mode 2: arm at stop_word.
    task automatic read_window(input logic [7:0] first, input int stall_word, input int stall_len,
                               input int stop_word, input int stop_mode);
        int         waited;
        logic       saw_done;
        logic [10:0] exp;
        waited   = 0;
        saw_done = 1'b0;
        while (!out_if.out_valid && waited < 100) begin
            if (sampler_ready && !out_if.out_valid) saw_done = 1'b1;
            cycle(1'b0, 1'b1, 1'b1);
            waited++;
        end
        chk("wait_valid", out_if.out_valid, 1);
        chk("done_ready_no_valid", saw_done, 1);
        for (int w = 0; w < 16; w++) begin
            exp = exp_word(first + 8'(w));
            chk("word", out_if.out_data, exp);
            chk("last", out_if.out_last, (w == 15));
            chk("ready_in_read", sampler_ready, 1);
            if (w == stop_word && stop_mode == 1) begin
                rst_n = 1'b0;
                #1;
                chk("rst_valid", out_if.out_valid, 0);
                chk("rst_ready", sampler_ready, 0);
                chk("rst_data", out_if.out_data, 0);
                #2;
                rst_n = 1'b1;
                for (int i = 0; i < 10; i++) begin
                    cycle(1'b0, i[0], 1'b1);
                    chk("idle_after_rst_valid", out_if.out_valid, 0);
                    chk("idle_after_rst_ready", sampler_ready, 0);
                end
                return;
            end
            if (w == stop_word && stop_mode == 2) begin
                cycle(1'b1, 1'b1, 1'b1);
                chk("abort_valid", out_if.out_valid, 0);
                chk("abort_ready", sampler_ready, 0);
                return;
            end
            if (w == stall_word) begin
                for (int s = 0; s < stall_len; s++) begin
                    cycle(1'b0, 1'b1, 1'b0);
                    chk("stall_valid", out_if.out_valid, 1);
                    chk("stall_word", out_if.out_data, exp);
                    chk("stall_last", out_if.out_last, (w == 15));
                end
            end
            cycle(1'b0, 1'b1, 1'b1);
        end
        chk("end_valid", out_if.out_valid, 0);
        chk("end_ready", sampler_ready, 0);
    endtask

    initial begin
        out_if.out_ready = 1'b0;
        #1;
        chk("reset_ready", sampler_ready, 0);
        chk("reset_valid", out_if.out_valid, 0);
        chk("reset_last", out_if.out_last, 0);
        chk("reset_data", out_if.out_data, 0);
        #12;
        rst_n = 1'b1;
        cycle(1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 1'b1);
        chk("idle_valid", out_if.out_valid, 0);

        // Basic window: arm at led=0x00, edge at led=0x20 -> words 0x1C..0x2B.
        $display("[TB] basic window");
        ledv = 8'h00;
        cycle(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 31; i++) cycle(1'b0, 1'b0, 1'b1);
        chk("basic_not_ready", sampler_ready, 0);
        chk("basic_edge_led", ledv, 8'h20);
        cycle(1'b0, 1'b1, 1'b1);
        read_window(8'h1C, -1, 0, -1, 0);

        // Trigger held high through arm and FILL: only a fresh edge captures.
        $display("[TB] trigger held high");
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b1);
        cycle(1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 14; i++) cycle(1'b0, 1'b1, 1'b1);
        chk("held_no_capture", sampler_ready, 0);
        chk("held_no_valid", out_if.out_valid, 0);
        capture(1, edge_led);
        read_window(edge_led - 8'd4, -1, 0, -1, 0);

        // Pulse in FILL ignored; later WAIT edge captures, with a 5-cycle stall at word 7.
        $display("[TB] fill pulse and stall");
        cycle(1'b1, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 20; i++) cycle(1'b0, 1'b0, 1'b1);
        chk("fill_pulse_ignored", sampler_ready, 0);
        capture(3, edge_led);
        read_window(edge_led - 8'd4, 7, 5, -1, 0);

        // Asynchronous reset in READ at word 9.
        $display("[TB] reset during read");
        cycle(1'b1, 1'b0, 1'b1);
        capture(10, edge_led);
        read_window(edge_led - 8'd4, -1, 0, 9, 1);

        // Arm during READ at word 3, then a full new window.
        $display("[TB] arm during read");
        cycle(1'b1, 1'b0, 1'b1);
        capture(8, edge_led);
        read_window(edge_led - 8'd4, -1, 0, 3, 2);
        capture(10, edge_led);
        read_window(edge_led - 8'd4, -1, 0, -1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/led_stream_sampler.md
LED_STREAM_SAMPLER -- requirements
Module: led_stream_sampler

Interface
REQ-001 SHALL have parameter DEPTH, default 16: capture buffer entries, power of 2, range 4..256.
REQ-002 SHALL have parameter PRE_TRIG, default 4: samples retained before the trigger, range 1..DEPTH-1.
REQ-003 SHALL have port clk, input, 1 bit: single clock, all state on the rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port led, input, 8 bits: probed LED vector.
REQ-006 SHALL have port led_on_number, input, 3 bits: probed active-LED index.
REQ-007 SHALL have port arm, input, 1 bit: single-cycle pulse that starts a capture.
REQ-008 SHALL have port trigger_ext, input, 1 bit: external trigger level, synchronous to clk.
REQ-009 SHALL have port sampler_ready, output, 1 bit: the buffer holds a complete capture window.
REQ-010 SHALL have port out_valid, output, 1 bit: readout word available.
REQ-011 SHALL have port out_ready, input, 1 bit: consumer accepts the readout word.
REQ-012 SHALL have port out_data, output, 11 bits: readout word {led_on_number, led}.
REQ-013 SHALL have port out_last, output, 1 bit: marks the final word of the window.

Function
REQ-014 SHALL define sample = {led_on_number, led}, written every cycle in FILL, WAIT and POST at wr_ptr; wr_ptr increments mod DEPTH.
REQ-015 SHALL implement states IDLE, FILL, WAIT, POST, DONE and READ.
REQ-016 SHALL, in IDLE on arm=1, clear wr_ptr and the sample counter and enter FILL.
REQ-017 SHALL stay in FILL for exactly PRE_TRIG writes, then enter WAIT; trigger edges in FILL are ignored.
REQ-018 SHALL register trigger_ext into trig_d every cycle in every state; trigger edge = trigger_ext & ~trig_d.
REQ-019 SHALL, in WAIT, keep writing circularly; a trigger edge enters POST, and the sample written in the edge cycle is post-sample 1 at address trig_addr.
REQ-020 SHALL write exactly DEPTH-PRE_TRIG post samples including the edge-cycle sample, then enter DONE.
REQ-021 SHALL set sampler_ready=1 from entry into DONE until the cycle after the final READ handshake; out_valid=0 in DONE.
REQ-022 SHALL set the read start to rd_ptr=(trig_addr-PRE_TRIG) mod DEPTH and load out_data from that address in DONE, then enter READ after 1 cycle.
REQ-023 SHALL hold out_valid=1 throughout READ; a transfer occurs on out_valid&out_ready, after which rd_ptr increments mod DEPTH and the next word loads in the same edge.
REQ-024 SHALL keep out_data and out_last stable while out_valid=1 and out_ready=0.
REQ-025 SHALL emit DEPTH words oldest-first and assert out_last only on word DEPTH.
REQ-026 SHALL enter IDLE after the out_last transfer, with out_valid=0 and sampler_ready=0 on the next cycle.
REQ-027 SHALL treat arm in FILL/WAIT/POST as a restart: clear pointers and re-enter FILL.
REQ-028 SHALL treat arm in DONE/READ as an abort and restart: out_valid=0 and sampler_ready=0 next cycle, enter FILL.
REQ-029 SHALL give arm priority over a simultaneous final handshake or trigger edge.

Reset
REQ-030 SHALL, on rst_n=0 and immediately (asynchronous): state=IDLE; wr_ptr, rd_ptr, counters and trig_d=0; sampler_ready, out_valid, out_last and out_data=0.
REQ-031 SHALL not reset buffer contents; these are unreadable until a new capture completes.
REQ-032 SHALL, on reset released mid-operation, wait in IDLE for arm with no output activity.

Verification (DEPTH=16, PRE_TRIG=4)
REQ-033 SHALL cover: led increments by 1 per cycle from 0x00, arm at led=0x00, trigger edge in the cycle where led=0x20 -> 16 words with led 0x1C..0x2B, out_last on 0x2B, sampler_ready high throughout.
REQ-034 SHALL cover: trigger_ext held high before arm and through FILL -> no capture; low for 1 cycle then high -> capture with that edge as post-sample 1.
REQ-035 SHALL cover: trigger pulse on the 2nd FILL cycle -> ignored, sampler_ready stays 0, and a later edge in WAIT captures correctly.
REQ-036 SHALL cover: out_ready=0 for 5 cycles at word 7 -> out_data/out_last stable, no dropped or duplicated words, 16 words total.
REQ-037 SHALL cover: rst_n=0 during READ at word 9 -> out_valid and sampler_ready 0 without a clock edge; no output after release until arm.
REQ-038 SHALL cover: arm during READ at word 3 -> out_valid=0 next cycle, a new capture completes, and a full 16-word window is emitted.
